// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR request scheduler.
// The default widths here also seed the scheduler's parameters.
package ddr_sched_pkg;

    function automatic int cnt_width(input int turn);
        return (turn < 1) ? 1 : $clog2(turn + 1);
    endfunction

    localparam int NUM_PORTS   = 4;
    localparam int ADDR_W      = 32;
    localparam int FIFO_DEPTH  = 8;
    localparam int TURN_CYCLES = 2;
    localparam int PORT_W      = $clog2(NUM_PORTS);
    localparam int CNT_W       = cnt_width(TURN_CYCLES);

    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [PORT_W-1:0] port;
    } ddr_cmd_t;

endpackage

// File: rtl/ddr_req_sched_if.sv
// Requester and controller-side signals of the DDR request scheduler.
// The scheduler uses the slave modport; the environment uses master.
interface ddr_req_sched_if #(
    parameter int NUM_PORTS  = ddr_sched_pkg::NUM_PORTS,
    parameter int ADDR_W     = ddr_sched_pkg::ADDR_W,
    parameter int FIFO_DEPTH = ddr_sched_pkg::FIFO_DEPTH
);
    localparam int PORT_W  = $clog2(NUM_PORTS);
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0]        req_ready;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_we;
    logic [ADDR_W-1:0]           cmd_addr;
    logic [PORT_W-1:0]           cmd_port;
    logic [COUNT_W-1:0]          fifo_count;
    logic                        busy;

    modport slave (
        input  req_valid, req_we, req_addr, cmd_ready,
        output req_ready, cmd_valid, cmd_we, cmd_addr, cmd_port, fifo_count, busy
    );

    modport master (
        output req_valid, req_we, req_addr, cmd_ready,
        input  req_ready, cmd_valid, cmd_we, cmd_addr, cmd_port, fifo_count, busy
    );
endinterface

// File: rtl/ddr_cmd_fifo.sv
// Synchronous command FIFO with registered storage and a combinational head.
// A pushed entry only becomes the head on the cycle after the push edge.
module ddr_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is deliberately not reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ddr_req_sched.sv
// Round-robin scheduler sharing one DDR command port among several requesters,
// with a FIFO in between and idle turnaround cycles on read/write direction changes.
module ddr_req_sched #(
    parameter int NUM_PORTS   = ddr_sched_pkg::NUM_PORTS,
    parameter int ADDR_W      = ddr_sched_pkg::ADDR_W,
    parameter int FIFO_DEPTH  = ddr_sched_pkg::FIFO_DEPTH,
    parameter int TURN_CYCLES = ddr_sched_pkg::TURN_CYCLES
) (
    input logic           clk,
    input logic           rst,
    ddr_req_sched_if.slave bus
);
    import ddr_sched_pkg::*;

    localparam int P_W = $clog2(NUM_PORTS);
    localparam int T_W = cnt_width(TURN_CYCLES);
    localparam int C_W = $clog2(FIFO_DEPTH + 1);
    localparam int D_W = 1 + ADDR_W + P_W;
    localparam logic [T_W-1:0] TURN_LOAD = T_W'(TURN_CYCLES);
    localparam logic [P_W:0]   PORTS_EXT = (P_W + 1)'(NUM_PORTS);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [P_W-1:0]    port;
    } cmd_t;

    logic [ADDR_W-1:0] port_addr [NUM_PORTS];
    logic [P_W-1:0]    last_grant_q, last_grant_d;
    logic              last_we_q, last_we_d;
    logic [T_W-1:0]    turn_cnt_q, turn_cnt_d;
    logic [P_W-1:0]    grant_idx;
    logic              grant_found;
    logic [P_W:0]      cand;
    logic              accept_ok;
    logic              fifo_full, fifo_empty;
    logic [C_W-1:0]    fifo_count;
    cmd_t              push_cmd, head_cmd;
    logic              head_is_write;
    logic              cmd_valid;
    logic              handshake;

    // Grants are gated by rst so nothing is accepted while reset is held.
    assign accept_ok = rst && !fifo_full && grant_found;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_addr[gi]     = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign bus.req_ready[gi] = accept_ok && (grant_idx == P_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = {1'b0, last_grant_q} + (P_W + 1)'(k);
            if (cand >= PORTS_EXT) begin
                cand = cand - PORTS_EXT;
            end
            if (!grant_found && bus.req_valid[cand[P_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[P_W-1:0];
            end
        end
    end

    always_comb begin
        push_cmd.we   = bus.req_we[grant_idx];
        push_cmd.addr = port_addr[grant_idx];
        push_cmd.port = grant_idx;
    end

    ddr_cmd_fifo #(
        .WIDTH (D_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept_ok),
        .push_data_i (push_cmd),
        .pop_i       (handshake),
        .head_o      (head_cmd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Same-direction heads ignore the turnaround counter entirely.
    assign head_is_write = (head_cmd.we == DIR_WRITE);
    assign cmd_valid     = !fifo_empty && ((head_is_write == last_we_q) || (turn_cnt_q == '0));
    assign handshake     = cmd_valid && bus.cmd_ready;

    assign bus.cmd_valid  = cmd_valid;
    assign bus.cmd_we     = head_is_write;
    assign bus.cmd_addr   = head_cmd.addr;
    assign bus.cmd_port   = head_cmd.port;
    assign bus.fifo_count = fifo_count;
    assign bus.busy       = !fifo_empty || (turn_cnt_q != '0);

    always_comb begin
        last_grant_d = last_grant_q;
        last_we_d    = last_we_q;
        turn_cnt_d   = turn_cnt_q;
        if (accept_ok) begin
            last_grant_d = grant_idx;
        end
        if (handshake) begin
            last_we_d  = head_is_write;
            turn_cnt_d = TURN_LOAD;
        end else if (turn_cnt_q != '0) begin
            turn_cnt_d = turn_cnt_q - T_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= P_W'(NUM_PORTS - 1);
            last_we_q    <= DIR_READ;
            turn_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            last_we_q    <= last_we_d;
            turn_cnt_q   <= turn_cnt_d;
        end
    end
endmodule

// File: tb/tb_ddr_req_sched.sv
// Directed bench for ddr_req_sched: reset, single request, fairness, turnaround,
// full/backpressure, pointer wrap and mid-operation reset, plus a stall-stability monitor.
module tb_ddr_req_sched;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ddr_req_sched_if #(.NUM_PORTS(4), .ADDR_W(32), .FIFO_DEPTH(8)) bus ();

    ddr_req_sched #(
        .NUM_PORTS   (4),
        .ADDR_W      (32),
        .FIFO_DEPTH  (8),
        .TURN_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int p, input logic [31:0] a);
        bus.req_addr[p*32 +: 32] = a;
    endtask

    // Once cmd_valid is up without cmd_ready, the command must hold unchanged.
    logic        stall_pend = 1'b0;
    logic [31:0] s_addr;
    logic        s_we;
    logic [1:0]  s_port;
    always @(negedge clk) begin
        if (!rst) begin
            stall_pend <= 1'b0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid", 64'(bus.cmd_valid), 64'd1);
                chk("stall_addr", 64'(bus.cmd_addr), 64'(s_addr));
                chk("stall_we", 64'(bus.cmd_we), 64'(s_we));
                chk("stall_port", 64'(bus.cmd_port), 64'(s_port));
            end
            stall_pend <= bus.cmd_valid && !bus.cmd_ready;
            s_addr     <= bus.cmd_addr;
            s_we       <= bus.cmd_we;
            s_port     <= bus.cmd_port;
        end
    end

    logic [31:0] exp_q[$];
    int          n_acc;
    int          n_iss;

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.cmd_ready = 1'b0;
        #1 rst = 1'b0;

        // ---- reset state, with requests already pending ----
        bus.req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'h0);
        chk("rst_count", 64'(bus.fifo_count), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        tick();
        tick();
        rst           = 1'b1;
        bus.req_valid = '0;

        // ---- single request: port 2 write to 0x100 ----
        bus.req_valid = 4'b0100;
        bus.req_we    = 4'b0100;
        set_addr(2, 32'h0000_0100);
        bus.cmd_ready = 1'b1;
        #1;
        chk("single_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_valid", 64'(bus.cmd_valid), 64'h1);
        chk("single_we", 64'(bus.cmd_we), 64'h1);
        chk("single_addr", 64'(bus.cmd_addr), 64'h100);
        chk("single_port", 64'(bus.cmd_port), 64'h2);
        chk("single_count1", 64'(bus.fifo_count), 64'h1);
        tick();
        chk("single_count0", 64'(bus.fifo_count), 64'h0);
        chk("single_busy_t2", 64'(bus.busy), 64'h1);
        tick();
        chk("single_busy_t1", 64'(bus.busy), 64'h1);
        tick();
        chk("single_busy_t0", 64'(bus.busy), 64'h0);

        // ---- fairness: all ports read; last grant was 2 so order is 3,0,1,2,... ----
        bus.req_valid = 4'hF;
        bus.req_we    = 4'h0;
        for (int p = 0; p < 4; p++) set_addr(p, 32'h1000 + 32'(p));
        #1;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("fair_grant%0d", j), 64'(bus.req_ready), 64'(4'b0001 << ((3 + j) % 4)));
            if (j == 0) begin
                chk("fair_idle0", 64'(bus.cmd_valid), 64'h0);
            end else begin
                chk($sformatf("fair_valid%0d", j), 64'(bus.cmd_valid), 64'h1);
                chk($sformatf("fair_port%0d", j), 64'(bus.cmd_port), 64'((3 + j - 1) % 4));
            end
            tick();
            #1;
        end
        bus.req_valid = '0;
        #1;
        chk("fair_tail_count", 64'(bus.fifo_count), 64'h1);
        chk("fair_tail_port", 64'(bus.cmd_port), 64'h2);
        tick();
        chk("fair_drained", 64'(bus.fifo_count), 64'h0);
        tick();
        tick();

        // ---- turnaround: write then read already queued ----
        bus.cmd_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_we    = 4'b0001;
        set_addr(0, 32'h10);
        #1;
        chk("turn_grant_w", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0010;
        bus.req_we    = 4'b0000;
        set_addr(1, 32'h20);
        #1;
        chk("turn_grant_r", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = '0;
        #1;
        chk("turn_count2", 64'(bus.fifo_count), 64'h2);
        chk("turn_w_valid", 64'(bus.cmd_valid), 64'h1);
        chk("turn_w_we", 64'(bus.cmd_we), 64'h1);
        chk("turn_w_addr", 64'(bus.cmd_addr), 64'h10);
        bus.cmd_ready = 1'b1;
        tick();
        chk("turn_gap1", 64'(bus.cmd_valid), 64'h0);
        tick();
        chk("turn_gap2", 64'(bus.cmd_valid), 64'h0);
        tick();
        chk("turn_r_valid", 64'(bus.cmd_valid), 64'h1);
        chk("turn_r_we", 64'(bus.cmd_we), 64'h0);
        chk("turn_r_addr", 64'(bus.cmd_addr), 64'h20);
        chk("turn_r_port", 64'(bus.cmd_port), 64'h1);
        tick();
        tick();
        tick();

        // ---- turnaround absorbed by an idle gap of two cycles ----
        bus.req_valid = 4'b0001;
        bus.req_we    = 4'b0001;
        set_addr(0, 32'h30);
        tick();
        bus.req_valid = '0;
        #1;
        chk("gap_w_valid", 64'(bus.cmd_valid), 64'h1);
        chk("gap_w_addr", 64'(bus.cmd_addr), 64'h30);
        tick();
        tick();
        chk("gap_idle", 64'(bus.cmd_valid), 64'h0);
        bus.req_valid = 4'b0010;
        bus.req_we    = 4'b0000;
        set_addr(1, 32'h40);
        tick();
        bus.req_valid = '0;
        #1;
        chk("gap_r_valid", 64'(bus.cmd_valid), 64'h1);
        chk("gap_r_we", 64'(bus.cmd_we), 64'h0);
        chk("gap_r_addr", 64'(bus.cmd_addr), 64'h40);
        tick();
        chk("gap_drained", 64'(bus.fifo_count), 64'h0);

        // ---- full and backpressure ----
        bus.cmd_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_we    = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            set_addr(0, 32'h200 + 32'(k));
            tick();
        end
        #1;
        chk("full_count", 64'(bus.fifo_count), 64'h8);
        chk("full_no_ready", 64'(bus.req_ready), 64'h0);
        chk("full_head", 64'(bus.cmd_addr), 64'h200);
        bus.cmd_ready = 1'b1;
        #1;
        chk("full_pop_no_ready", 64'(bus.req_ready), 64'h0);
        tick();
        bus.cmd_ready = 1'b0;
        set_addr(0, 32'h208);
        #1;
        chk("full_count7", 64'(bus.fifo_count), 64'h7);
        chk("full_reready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        #1;
        chk("full_refill", 64'(bus.fifo_count), 64'h8);
        bus.cmd_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("full_drain%0d", k), 64'(bus.cmd_addr), 64'(32'h200 + 32'(k)));
            tick();
        end
        chk("full_empty", 64'(bus.fifo_count), 64'h0);
        tick();
        tick();

        // ---- wrap-around: 20 reads on port 3 with cmd_ready toggling ----
        n_acc = 0;
        n_iss = 0;
        bus.cmd_ready = 1'b1;
        bus.req_valid = 4'b1000;
        bus.req_we    = 4'b0000;
        set_addr(3, 32'h3000);
        for (int cyc = 0; cyc < 200 && n_iss < 20; cyc++) begin
            #1;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("wrap_extra", 64'(bus.cmd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk($sformatf("wrap_addr%0d", n_iss), 64'(bus.cmd_addr), 64'(exp_q.pop_front()));
                end
                n_iss++;
            end
            if (bus.req_valid[3] && bus.req_ready[3]) begin
                exp_q.push_back(32'h3000 + 32'(n_acc));
                n_acc++;
            end
            tick();
            bus.cmd_ready = ~bus.cmd_ready;
            bus.req_valid = (n_acc < 20) ? 4'b1000 : 4'b0000;
            set_addr(3, 32'h3000 + 32'(n_acc));
        end
        chk("wrap_issued", 64'(n_iss), 64'd20);
        chk("wrap_accepted", 64'(n_acc), 64'd20);
        #1;
        chk("wrap_empty", 64'(bus.fifo_count), 64'h0);
        bus.cmd_ready = 1'b0;
        tick();
        tick();
        tick();

        // ---- reset mid-operation: 5 reads queued, turnaround counter at 1 ----
        bus.req_valid = 4'b0001;
        bus.req_we    = 4'b0001;
        set_addr(0, 32'h500);
        tick();
        bus.req_valid = 4'b0010;
        bus.req_we    = 4'b0000;
        set_addr(1, 32'h600);
        for (int k = 0; k < 5; k++) tick();
        bus.req_valid = '0;
        #1;
        chk("mid_count6", 64'(bus.fifo_count), 64'h6);
        chk("mid_w_addr", 64'(bus.cmd_addr), 64'h500);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        tick();
        chk("mid_count5", 64'(bus.fifo_count), 64'h5);
        chk("mid_busy", 64'(bus.busy), 64'h1);
        chk("mid_blocked", 64'(bus.cmd_valid), 64'h0);
        bus.req_valid = 4'hF;
        bus.req_we    = 4'hF;
        set_addr(0, 32'h700);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.cmd_valid), 64'h0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'h0);
        chk("mid_rst_count", 64'(bus.fifo_count), 64'h0);
        chk("mid_rst_busy", 64'(bus.busy), 64'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_grant", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        #1;
        chk("post_rst_valid", 64'(bus.cmd_valid), 64'h1);
        chk("post_rst_port", 64'(bus.cmd_port), 64'h0);
        chk("post_rst_we", 64'(bus.cmd_we), 64'h1);
        chk("post_rst_addr", 64'(bus.cmd_addr), 64'h700);
        chk("post_rst_count", 64'(bus.fifo_count), 64'h1);
        bus.cmd_ready = 1'b1;
        tick();
        chk("post_rst_drained", 64'(bus.fifo_count), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
